// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The FSM side drives every select/enable; the datapath side supplies opcode and zero.
interface multicycle_control_fsm_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               i_or_d;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               reg_dst;
  logic               mem_to_reg;
  logic [1:0]         pc_src;
  logic [1:0]         alu_op;
  logic               ir_write;
  logic               mem_write;
  logic               reg_write;
  logic               pc_en;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, zero,
    output i_or_d, alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_src, alu_op,
           ir_write, mem_write, reg_write, pc_en, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero,
    input  i_or_d, alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_src, alu_op,
           ir_write, mem_write, reg_write, pc_en, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle MIPS datapath: Moore FSM stepping through
// fetch/decode/execute/memory/writeback; pc_en alone also depends on zero.
module multicycle_control_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_control_fsm_if.master ctl
);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  typedef enum logic [STATE_W-1:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t state_q, state_n;
  logic   pc_write, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n        = IDLE;
    pc_write       = 1'b0;
    branch         = 1'b0;
    ctl.i_or_d     = 1'b0;
    ctl.alu_src_a  = 1'b0;
    ctl.alu_src_b  = 2'b00;
    ctl.reg_dst    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.pc_src     = 2'b00;
    ctl.alu_op     = 2'b00;
    ctl.ir_write   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.illegal_op = 1'b0;
    case (state_q)
      IDLE: state_n = FETCH;
      FETCH: begin
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = 1'b1;
        pc_write      = 1'b1;
        state_n       = DECODE;
      end
      // opcode is trusted only here and in MEMADR, where IR cannot change
      DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (ctl.opcode)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYP:      state_n = EXECUTE;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JUMP;
          default: begin
            ctl.illegal_op = 1'b1;
            state_n        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_n       = (ctl.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctl.i_or_d = 1'b1;
        state_n    = MEMWB;
      end
      MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        state_n        = FETCH;
      end
      MEMWR: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_write = 1'b1;
        state_n       = FETCH;
      end
      EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_n       = ALUWB;
      end
      ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        state_n       = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b01;
        ctl.pc_src    = 2'b01;
        branch        = 1'b1;
        state_n       = FETCH;
      end
      ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_n       = ADDIWB;
      end
      ADDIWB: begin
        ctl.reg_write = 1'b1;
        state_n       = FETCH;
      end
      JUMP: begin
        ctl.pc_src = 2'b10;
        pc_write   = 1'b1;
        state_n    = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  // Branch decision follows zero combinationally within the BRANCH cycle
  assign ctl.pc_en     = pc_write | (branch & ctl.zero);
  assign ctl.state_dbg = state_q;
endmodule
